// File: rtl/key_panel_pkg.sv
// rtl/key_panel_pkg.sv - shared constants and cycle-count helpers for the key panel
//
// Purpose : system clock rate and the millisecond/second to cycle-count
//           conversions used for the debounce and repeat parameter defaults.
// Ports   : none (package).
package key_panel_pkg;

   localparam int CLK_HZ = 50_000_000;
   localparam int NKEYS  = 4;

   // Cycle count for a duration in milliseconds at CLK_HZ.
   function automatic int c_ms(input int ms);
      return int'((longint'(ms) * longint'(CLK_HZ)) / 1000);
   endfunction

   // Cycle count for a duration in seconds at CLK_HZ.
   function automatic int c_s(input int s);
      return s * CLK_HZ;
   endfunction

endpackage

// File: rtl/key_panel_if.sv
// rtl/key_panel_if.sv - board-side key inputs and controller-side trigger outputs
//
// Purpose : bundles the four raw key pins and the four trigger pulses.
// Ports   : key_pwr/key_mod/key_run/key_wat  raw active-high keys (asynchronous)
//           tr_pwr/tr_mod/tr_run/tr_wat      one-cycle triggers to the controller
// Modports: master - board/controller side (drives keys, receives triggers)
//           slave  - the key panel (receives keys, drives triggers)
interface key_panel_if;

   logic key_pwr;
   logic key_mod;
   logic key_run;
   logic key_wat;
   logic tr_pwr;
   logic tr_mod;
   logic tr_run;
   logic tr_wat;

   modport master (
      output key_pwr, key_mod, key_run, key_wat,
      input  tr_pwr,  tr_mod,  tr_run,  tr_wat
   );

   modport slave (
      input  key_pwr, key_mod, key_run, key_wat,
      output tr_pwr,  tr_mod,  tr_run,  tr_wat
   );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-level debounce for one key
//
// Purpose : brings one raw asynchronous key into the clk domain and accepts a
//           new level only after it has held for CMAX consecutive cycles.
// Ports   : clk     system clock
//           rst_n   asynchronous active-low reset
//           raw     raw key level, asynchronous to clk
//           stable  debounced level
//           rise    combinational; high in the cycle whose edge raises stable
module key_debounce #(
   parameter int CMAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);

   // The counter only needs to reach CMAX-1.
   localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CMAX - 1);

   logic          s1_q, s2_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // The synced level has differed from stable for CMAX cycles including this one.
   assign accept = (s2_q != stable_q) && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d    = '0;
         stable_d = s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign stable = stable_q;
   assign rise   = accept & s2_q;

endmodule

// File: rtl/key_panel.sv
// rtl/key_panel.sv - debounced panel keys with water auto-repeat and one-hot trigger arbiter
//
// Purpose : debounces the four panel keys, turns accepted presses (and water
//           auto-repeats) into pending requests, and releases at most one
//           registered trigger pulse per clock in priority pwr > mod > run > wat.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset
//           bus    key_panel_if.slave - raw keys in, tr_* triggers out
module key_panel
   import key_panel_pkg::*;
#(
   parameter int DB_CMAX = c_ms(20),
   parameter int REP_DLY = c_ms(600),
   parameter int REP_PER = c_ms(200)
) (
   input  logic        clk,
   input  logic        rst_n,
   key_panel_if.slave  bus
);

   // Bit indices double as the priority order: lower index wins.
   localparam int K_PWR = 0;
   localparam int K_MOD = 1;
   localparam int K_RUN = 2;
   localparam int K_WAT = 3;

   logic [NKEYS-1:0] raw;
   logic [NKEYS-1:0] stable;
   logic [NKEYS-1:0] rise;
   logic             rep_evt;
   logic [NKEYS-1:0] evt;
   logic [NKEYS-1:0] grant;
   logic [NKEYS-1:0] pend_q, pend_d;
   logic [NKEYS-1:0] tr_q;

   assign raw[K_PWR] = bus.key_pwr;
   assign raw[K_MOD] = bus.key_mod;
   assign raw[K_RUN] = bus.key_run;
   assign raw[K_WAT] = bus.key_wat;

   for (genvar g = 0; g < NKEYS; g++) begin : g_db
      key_debounce #(
         .CMAX (DB_CMAX)
      ) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (raw[g]),
         .stable (stable[g]),
         .rise   (rise[g])
      );
   end

   // Water auto-repeat: rcnt measures the first REP_DLY interval after the
   // press, then successive REP_PER intervals (per_q marks which one is running).
   if (REP_DLY != 0) begin : g_rep
      localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
      localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
      localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
      localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          per_q, per_d;
      logic          hit;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rcnt_q <= '0;
            per_q  <= 1'b0;
         end else begin
            rcnt_q <= rcnt_d;
            per_q  <= per_d;
         end
      end

      always_comb begin
         rcnt_d = rcnt_q;
         per_d  = per_q;
         hit    = 1'b0;
         // A fresh press restarts timing; a released key holds the counter idle.
         if (rise[K_WAT] || !stable[K_WAT]) begin
            rcnt_d = '0;
            per_d  = 1'b0;
         end else if (rcnt_q == (per_q ? PER_LAST : DLY_LAST)) begin
            hit    = 1'b1;
            rcnt_d = '0;
            per_d  = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end

      assign rep_evt = hit;
   end else begin : g_no_rep
      assign rep_evt = 1'b0;
   end

   always_comb begin
      evt        = rise;
      evt[K_WAT] = rise[K_WAT] | rep_evt;
   end

   always_comb begin
      grant = '0;
      if (pend_q[K_PWR])      grant[K_PWR] = 1'b1;
      else if (pend_q[K_MOD]) grant[K_MOD] = 1'b1;
      else if (pend_q[K_RUN]) grant[K_RUN] = 1'b1;
      else if (pend_q[K_WAT]) grant[K_WAT] = 1'b1;
   end

   // OR-ing events after the clear makes a coincident new event survive the
   // grant, while repeated events on a waiting request simply merge.
   assign pend_d = (pend_q & ~grant) | evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         tr_q   <= '0;
      end else begin
         pend_q <= pend_d;
         tr_q   <= grant;
      end
   end

   assign bus.tr_pwr = tr_q[K_PWR];
   assign bus.tr_mod = tr_q[K_MOD];
   assign bus.tr_run = tr_q[K_RUN];
   assign bus.tr_wat = tr_q[K_WAT];

endmodule

// File: tb/tb_key_panel.sv
// tb/tb_key_panel.sv - directed table-driven bench for key_panel
module tb_key_panel;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_panel_if bus_a ();
   key_panel_if bus_b ();

   key_panel #(.DB_CMAX(4), .REP_DLY(20), .REP_PER(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   // Short repeat timing so a repeat event can land on a waiting wat request.
   key_panel #(.DB_CMAX(4), .REP_DLY(2), .REP_PER(2)) dut_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      int c;
      int k;
   } pulse_t;

   typedef struct {
      string            name;
      logic [3:0]       keys;
      int               hold;
      logic [3:0][7:0]  exp_n;
      logic [3:0][7:0]  exp_rel;
   } vec_t;

   pulse_t log_a[$];
   int     log_b[$];
   int     excl_bad = 0;
   int     n_chk    = 0;
   int     n_fail   = 0;

   // Pulse recorder, away from the active edge; cyc equals the edge that launched the pulse.
   always @(negedge clk) begin
      logic [3:0] ta;
      logic [3:0] tb2;
      pulse_t     p;
      ta  = {bus_a.tr_wat, bus_a.tr_run, bus_a.tr_mod, bus_a.tr_pwr};
      tb2 = {bus_b.tr_wat, bus_b.tr_run, bus_b.tr_mod, bus_b.tr_pwr};
      for (int k = 0; k < 4; k++) begin
         if (ta[k]) begin
            p.c = cyc;
            p.k = k;
            log_a.push_back(p);
         end
      end
      if (bus_b.tr_wat) log_b.push_back(cyc);
      if ($countones(ta) > 1 || $countones(tb2) > 1) excl_bad++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int count_k(input int k);
      int n = 0;
      foreach (log_a[i]) if (log_a[i].k == k) n++;
      return n;
   endfunction

   function automatic int first_k(input int k);
      foreach (log_a[i]) if (log_a[i].k == k) return log_a[i].c;
      return -1;
   endfunction

   task automatic set_keys(input logic [3:0] k);
      bus_a.key_pwr = k[0];
      bus_a.key_mod = k[1];
      bus_a.key_run = k[2];
      bus_a.key_wat = k[3];
   endtask

   // Hold keys for 'hold' sampling edges starting at edge t0, then idle.
   task automatic apply(input logic [3:0] keys, input int hold, output int t0);
      @(negedge clk);
      t0 = cyc + 1;
      set_keys(keys);
      repeat (hold) @(negedge clk);
      set_keys(4'b0000);
      repeat (30) @(negedge clk);
   endtask

   function automatic vec_t mk(input string nm, input logic [3:0] keys, input int hold,
                               input int n0, input int n1, input int n2, input int n3,
                               input int r0, input int r1, input int r2, input int r3);
      vec_t v;
      v.name       = nm;
      v.keys       = keys;
      v.hold       = hold;
      v.exp_n[0]   = 8'(n0);
      v.exp_n[1]   = 8'(n1);
      v.exp_n[2]   = 8'(n2);
      v.exp_n[3]   = 8'(n3);
      v.exp_rel[0] = 8'(r0);
      v.exp_rel[1] = 8'(r1);
      v.exp_rel[2] = 8'(r2);
      v.exp_rel[3] = 8'(r3);
      return v;
   endfunction

   vec_t vt[7];
   int   rep_exp[6]  = '{7, 27, 35, 43, 51, 59};
   int   merge_exp[3] = '{10, 11, 13};
   int   bpat[8]     = '{1, 1, 0, 0, 1, 1, 0, 0};

   initial begin
      int t0;
      int t1;
      int nwin;
      logic [3:0] trv;

      // keys bit order: [0]=pwr [1]=mod [2]=run [3]=wat; rel = cycles from first high sample
      vt[0] = mk("mod_clean",   4'b0010, 20, 0, 1, 0, 0,  0, 7, 0, 0);
      vt[1] = mk("pwr_wat_sim", 4'b1001, 12, 1, 0, 0, 1,  7, 0, 0, 8);
      vt[2] = mk("run_glitch3", 4'b0100,  3, 0, 0, 0, 0,  0, 0, 0, 0);
      vt[3] = mk("run_min4",    4'b0100,  4, 0, 0, 1, 0,  0, 0, 7, 0);
      vt[4] = mk("all_four",    4'b1111, 12, 1, 1, 1, 1,  7, 8, 9, 10);
      vt[5] = mk("mod_run",     4'b0110, 10, 0, 1, 1, 0,  0, 7, 8, 0);
      vt[6] = mk("wat_short",   4'b1000, 15, 0, 0, 0, 1,  0, 0, 0, 7);

      set_keys(4'b0000);
      bus_b.key_pwr = 1'b0;
      bus_b.key_mod = 1'b0;
      bus_b.key_run = 1'b0;
      bus_b.key_wat = 1'b0;

      // Reset state
      repeat (3) begin
         @(negedge clk);
         trv = {bus_a.tr_wat, bus_a.tr_run, bus_a.tr_mod, bus_a.tr_pwr};
         check("reset_tr", int'(trv), 0);
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_pulse", log_a.size(), 0);

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         log_a.delete();
         apply(vt[i].keys, vt[i].hold, t0);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_cnt%0d", vt[i].name, k), count_k(k), int'(vt[i].exp_n[k]));
            if (vt[i].exp_n[k] != 0)
               check($sformatf("%s_rel%0d", vt[i].name, k), first_k(k) - t0 + 1,
                     int'(vt[i].exp_rel[k]));
         end
      end

      // Bounce on run, final rising sample at t0+8
      log_a.delete();
      @(negedge clk);
      t0 = cyc + 1;
      for (int i = 0; i < 8; i++) begin
         bus_a.key_run = bpat[i][0];
         @(negedge clk);
      end
      bus_a.key_run = 1'b1;
      repeat (15) @(negedge clk);
      bus_a.key_run = 1'b0;
      repeat (30) @(negedge clk);
      check("bounce_total", log_a.size(), 1);
      check("bounce_run_cnt", count_k(2), 1);
      check("bounce_run_rel", first_k(2) - (t0 + 8) + 1, 7);

      // Water auto-repeat: stable rises at rel 6, falls at rel 64 (clear of the rel-66 repeat)
      log_a.delete();
      apply(4'b1000, 58, t0);
      check("rep_total", log_a.size(), 6);
      check("rep_wat_cnt", count_k(3), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < log_a.size())
            check($sformatf("rep_time%0d", i), log_a[i].c - t0 + 1, rep_exp[i]);
      end

      // Merge on the fast instance: wat events at rel 6 and 8 share one pulse at rel 10
      log_b.delete();
      @(negedge clk);
      t0 = cyc + 1;
      bus_b.key_pwr = 1'b1;
      bus_b.key_mod = 1'b1;
      bus_b.key_run = 1'b1;
      bus_b.key_wat = 1'b1;
      repeat (14) @(negedge clk);
      bus_b.key_pwr = 1'b0;
      bus_b.key_mod = 1'b0;
      bus_b.key_run = 1'b0;
      bus_b.key_wat = 1'b0;
      repeat (30) @(negedge clk);
      nwin = 0;
      foreach (log_b[i]) if (log_b[i] - t0 + 1 <= 13) nwin++;
      check("merge_window_cnt", nwin, 3);
      for (int i = 0; i < 3; i++) begin
         if (i < log_b.size())
            check($sformatf("merge_time%0d", i), log_b[i] - t0 + 1, merge_exp[i]);
      end

      // Reset while mod is held
      log_a.delete();
      @(negedge clk);
      t0 = cyc + 1;
      bus_a.key_mod = 1'b1;
      repeat (10) @(negedge clk);
      check("prerst_mod_cnt", count_k(1), 1);
      check("prerst_mod_rel", first_k(1) - t0 + 1, 7);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         trv = {bus_a.tr_wat, bus_a.tr_run, bus_a.tr_mod, bus_a.tr_pwr};
         check("midrst_tr", int'(trv), 0);
      end
      log_a.delete();
      rst_n = 1'b1;
      t1 = cyc + 1;
      repeat (20) @(negedge clk);
      bus_a.key_mod = 1'b0;
      repeat (30) @(negedge clk);
      check("postrst_total", log_a.size(), 1);
      check("postrst_mod_cnt", count_k(1), 1);
      check("postrst_mod_rel", first_k(1) - t1 + 1, 7);

      check("mutex", excl_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
